// File: rtl/sd_block_read.sv
// sd_block_read: SPI-mode single-block (CMD17) reader for SDHC/SDXC cards.
// Issues CMD17 for a 32-bit block address, waits for R1 and the 0xFE data
// token, streams 512 bytes out MSB-first with a per-byte strobe, drops the
// 16-bit CRC and finishes with a rd_done pulse (rd_err set on any failure).
// MISO is sampled on the rising edge; everything else moves on the falling
// edge so MOSI/CS are stable when the card samples them.
module sd_block_read #(
  parameter int RESP_TIMEOUT  = 255,
  parameter int TOKEN_TIMEOUT = 65535
) (
  input  logic        SD_clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic [31:0] sec_addr,
  input  logic        SD_dataout,
  output logic        SD_cs,
  output logic        SD_datain,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_data_valid,
  output logic        rd_done,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_R1,
    WAIT_TOKEN,
    RD_DATA,
    RD_CRC,
    ERR,
    FINISH
  } state_t;

  localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [7:0]  CMD17      = 8'h51;
  localparam logic [7:0]  START_TOK  = 8'hFE;

  state_t      state;
  logic        din_r;
  logic [47:0] cmd_sr;     // command frame, shifted out MSB-first
  logic [15:0] cnt;        // cmd bits / timeout / CRC / finish cycles
  logic [2:0]  bit_cnt;    // bit position within the current byte
  logic [8:0]  byte_cnt;   // data byte index 0..511
  logic [7:0]  shift_sr;   // R1 capture, token window and data assembly
  logic        r1_active;  // R1 start bit seen, capturing remaining bits
  logic [7:0]  shift_next;

  // Byte window including the bit that arrived on the last rising edge.
  assign shift_next = {shift_sr[6:0], din_r};

  // Sample MISO on the rising edge, where the card guarantees it is stable.
  // NOTE: sequential state is always written with <= so every flop sees the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      din_r <= 1'b1;  // idle MISO level, so nothing looks like a start bit
    end else begin
      din_r <= SD_dataout;
    end
  end

  // Transfer sequencer: command, R1, token, data, CRC, then CS-high tail.
  always_ff @(negedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      SD_cs         <= 1'b1;
      SD_datain     <= 1'b1;
      rd_busy       <= 1'b0;
      rd_data       <= 8'h00;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
      rd_err        <= 1'b0;
      cmd_sr        <= '1;
      cnt           <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      shift_sr      <= '1;
      r1_active     <= 1'b0;
    end else begin
      // Strobes default low; the states below raise them for one cycle.
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;

      unique case (state)
        IDLE: begin
          SD_cs     <= 1'b1;
          SD_datain <= 1'b1;
          if (rd_req && init_done) begin
            cmd_sr  <= {CMD17, sec_addr, 8'hFF};
            rd_err  <= 1'b0;
            rd_busy <= 1'b1;
            cnt     <= '0;
            state   <= SEND_CMD;
          end
        end

        SEND_CMD: begin
          SD_cs     <= 1'b0;
          SD_datain <= cmd_sr[47];
          cmd_sr    <= {cmd_sr[46:0], 1'b1};
          if (cnt == 16'd47) begin
            cnt       <= '0;
            r1_active <= 1'b0;
            state     <= WAIT_R1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WAIT_R1: begin
          SD_cs     <= 1'b0;
          SD_datain <= 1'b1;
          if (r1_active) begin
            shift_sr <= shift_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              r1_active <= 1'b0;
              if (shift_next == 8'h00) begin
                // Preload all-ones so R1's zeros cannot alias into 0xFE.
                shift_sr <= '1;
                cnt      <= '0;
                state    <= WAIT_TOKEN;
              end else begin
                state <= ERR;
              end
            end
          end else if (!din_r) begin
            // The start bit is R1 bit 7 and is already a zero.
            r1_active <= 1'b1;
            shift_sr  <= 8'h00;
            bit_cnt   <= 3'd1;
          end else if (cnt == RESP_LAST) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WAIT_TOKEN: begin
          SD_cs     <= 1'b0;
          SD_datain <= 1'b1;
          shift_sr  <= shift_next;
          if (shift_next == START_TOK) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            state    <= RD_DATA;
          end else if (cnt == TOKEN_LAST) begin
            state <= ERR;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RD_DATA: begin
          SD_cs     <= 1'b0;
          SD_datain <= 1'b1;
          shift_sr  <= shift_next;
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rd_data       <= shift_next;
            rd_data_valid <= 1'b1;
            byte_cnt      <= byte_cnt + 9'd1;
            if (byte_cnt == 9'd511) begin
              cnt   <= '0;
              state <= RD_CRC;
            end
          end
        end

        RD_CRC: begin
          // CRC16 is clocked through and ignored.
          SD_cs     <= 1'b0;
          SD_datain <= 1'b1;
          if (cnt == 16'd15) begin
            cnt   <= '0;
            state <= FINISH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        ERR: begin
          rd_err    <= 1'b1;
          SD_cs     <= 1'b1;
          SD_datain <= 1'b1;
          cnt       <= '0;
          state     <= FINISH;
        end

        FINISH: begin
          // Eight CS-high cycles release the card before the next command.
          SD_cs     <= 1'b1;
          SD_datain <= 1'b1;
          if (cnt == 16'd8) begin
            rd_done <= 1'b1;
            rd_busy <= 1'b0;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: a behavioural SPI card answers CMD17; expected
// command frames and data bytes are queued when each request is issued and
// popped as the card receives the command and the DUT strobes data.
module tb_sd_block_read;

  localparam int MODE_GOOD    = 0;  // R1=0x00, token, 512 bytes, CRC
  localparam int MODE_R1_ERR  = 1;  // R1=0x05
  localparam int MODE_SILENT  = 2;  // MISO stays high
  localparam int MODE_NOTOKEN = 3;  // R1=0x00, never a token

  logic        SD_clk = 1'b0;
  logic        rst_n;
  logic        init_done;
  logic        rd_req;
  logic [31:0] sec_addr;
  logic        SD_dataout;
  logic        SD_cs;
  logic        SD_datain;
  logic        rd_busy;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic        rd_done;
  logic        rd_err;

  always #5 SD_clk = ~SD_clk;

  sd_block_read dut (
    .SD_clk        (SD_clk),
    .rst_n         (rst_n),
    .init_done     (init_done),
    .rd_req        (rd_req),
    .sec_addr      (sec_addr),
    .SD_dataout    (SD_dataout),
    .SD_cs         (SD_cs),
    .SD_datain     (SD_datain),
    .rd_busy       (rd_busy),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_done       (rd_done),
    .rd_err        (rd_err)
  );

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_cmd_q[$];
  logic [7:0]  exp_data_q[$];
  logic [1:0]  miso_q[$];      // {marks last token bit, MISO bit}

  int          card_mode = MODE_GOOD;
  int          c_bits = 0;
  bit          c_got = 1'b0;
  logic [47:0] c_sr = '0;
  logic [1:0]  tx_bit;

  int cyc = 0;
  int done_cnt = 0;
  int rd_valid_cnt = 0;
  int last_valid_cyc = 0;
  int first_valid_cyc = 0;
  int done_cyc = 0;
  int busy_cyc = 0;
  int tok_cyc = 0;
  int cs_run = 0;
  int cs_run_at_done = 0;
  bit busy_q = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input bit mark_last);
    for (int i = 7; i >= 0; i--) miso_q.push_back({mark_last && (i == 0), b[i]});
  endtask

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) miso_q.push_back(2'b01);
  endtask

  task automatic build_resp(input int mode);
    if (mode == MODE_SILENT) return;
    push_ones(10);
    push_byte((mode == MODE_R1_ERR) ? 8'h05 : 8'h00, 1'b0);
    if (mode != MODE_GOOD) return;
    push_ones(100);
    push_byte(8'hFE, 1'b1);
    for (int i = 0; i < 512; i++) push_byte(8'(i), 1'b0);
    push_byte(8'hBE, 1'b0);
    push_byte(8'hEF, 1'b0);
  endtask

  // Card receive side: collect the 48-bit command, then queue the reply.
  initial begin : card_rx
    forever begin
      @(posedge SD_clk);
      if (!rst_n || SD_cs) begin
        c_bits = 0;
        c_got  = 1'b0;
      end else if (!c_got) begin
        c_sr = {c_sr[46:0], SD_datain};
        c_bits++;
        if (c_bits == 48) begin
          c_got = 1'b1;
          check("cmd_expected", 64'(exp_cmd_q.size() != 0), 64'(1));
          if (exp_cmd_q.size() != 0) check("cmd_frame", 64'(c_sr), 64'(exp_cmd_q.pop_front()));
          build_resp(card_mode);
        end
      end
    end
  end

  // Card transmit side: MISO changes on the falling edge.
  initial begin : card_tx
    SD_dataout = 1'b1;
    forever begin
      @(negedge SD_clk);
      if (miso_q.size() != 0) begin
        tx_bit = miso_q.pop_front();
        SD_dataout = tx_bit[0];
        if (tx_bit[1]) tok_cyc = cyc;
      end else begin
        SD_dataout = 1'b1;
      end
    end
  end

  // Output monitor, sampled on the rising edge (outputs move on falling).
  initial begin : monitor
    forever begin
      @(posedge SD_clk);
      if (rd_data_valid) begin
        check("strobe_expected", 64'(exp_data_q.size() != 0), 64'(1));
        if (exp_data_q.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_data_q.pop_front()));
        if (rd_valid_cnt == 0) first_valid_cyc = cyc;
        else check("strobe_spacing", 64'(cyc - last_valid_cyc), 64'(8));
        last_valid_cyc = cyc;
        rd_valid_cnt++;
      end
      if (rd_done) begin
        done_cnt++;
        done_cyc = cyc;
        cs_run_at_done = cs_run;
      end
      if (rd_busy && !busy_q) busy_cyc = cyc;
      busy_q = rd_busy;
      cs_run = SD_cs ? cs_run + 1 : 0;
      cyc++;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},     64'(SD_cs),         64'(1));
    check({tag, "_mosi"},   64'(SD_datain),     64'(1));
    check({tag, "_busy"},   64'(rd_busy),       64'(0));
    check({tag, "_data"},   64'(rd_data),       64'(0));
    check({tag, "_valid"},  64'(rd_data_valid), 64'(0));
    check({tag, "_done"},   64'(rd_done),       64'(0));
    check({tag, "_err"},    64'(rd_err),        64'(0));
  endtask

  // Issue a request and queue what the card and the data port must see.
  task automatic start_read(input logic [31:0] addr, input int mode);
    exp_cmd_q.push_back({8'h51, addr, 8'hFF});
    if (mode == MODE_GOOD) for (int i = 0; i < 512; i++) exp_data_q.push_back(8'(i));
    card_mode    = mode;
    rd_valid_cnt = 0;
    sec_addr     = addr;
    rd_req       = 1'b1;
    @(negedge SD_clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    int  start = done_cnt;
    bit  seen  = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge SD_clk);
      #1;
      seen = (done_cnt != start);
    end
    check(tag, 64'(seen), 64'(1));
  endtask

  task automatic wait_valid(input int n, input int limit, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(posedge SD_clk);
      #1;
      ok = (rd_valid_cnt >= n);
    end
    check(tag, 64'(ok), 64'(1));
  endtask

  // Checks made on the cycle rd_done is visible after a good read.
  task automatic check_good_tail(input string tag);
    check({tag, "_err"},        64'(rd_err),                     64'(0));
    check({tag, "_busy"},       64'(rd_busy),                    64'(0));
    check({tag, "_nbytes"},     64'(rd_valid_cnt),               64'(512));
    check({tag, "_sb_empty"},   64'(exp_data_q.size()),          64'(0));
    // Match edge is one cycle after the card drives the last token bit.
    check({tag, "_tok_lat"},    64'(first_valid_cyc - tok_cyc),  64'(9));
    check({tag, "_done_lat"},   64'(done_cyc - last_valid_cyc),  64'(25));
    check({tag, "_cs_tail"},    64'(cs_run_at_done),             64'(8));
  endtask

  initial begin : stim
    int d0;
    bit gate_ok;

    rst_n     = 1'b0;
    init_done = 1'b0;
    rd_req    = 1'b0;
    sec_addr  = '0;
    repeat (3) @(posedge SD_clk);
    #1;
    check_reset_vals("reset");
    @(negedge SD_clk);
    #2;
    rst_n = 1'b1;

    // Request without init_done must be ignored.
    repeat (2) @(posedge SD_clk);
    #1;
    sec_addr = 32'h1111_2222;
    rd_req   = 1'b1;
    gate_ok  = 1'b1;
    repeat (20) begin
      @(posedge SD_clk);
      #1;
      if (SD_cs !== 1'b1 || rd_busy !== 1'b0) gate_ok = 1'b0;
    end
    rd_req = 1'b0;
    check("gated_idle", 64'(gate_ok), 64'(1));

    // Good read; a stray request and init_done drop mid-data are ignored.
    init_done = 1'b1;
    d0 = done_cnt;
    start_read(32'h0000_1234, MODE_GOOD);
    check("busy_on_accept", 64'(rd_busy), 64'(1));
    wait_valid(100, 3000, "good1_reach100");
    sec_addr = 32'hDEAD_BEEF;
    rd_req   = 1'b1;
    @(negedge SD_clk);
    #1;
    rd_req = 1'b0;
    wait_valid(300, 3000, "good1_reach300");
    init_done = 1'b0;
    wait_done(6000, "good1_done");
    init_done = 1'b1;
    check_good_tail("good1");
    repeat (20) @(posedge SD_clk);
    #1;
    check("good1_single_done", 64'(done_cnt - d0),       64'(1));
    check("good1_idle_cs",     64'(SD_cs),               64'(1));
    check("good1_no_recmd",    64'(exp_cmd_q.size()),    64'(0));

    // R1 error.
    start_read(32'h0000_0042, MODE_R1_ERR);
    wait_done(500, "r1err_done");
    check("r1err_flag",    64'(rd_err),       64'(1));
    check("r1err_no_data", 64'(rd_valid_cnt), 64'(0));
    check("r1err_busy",    64'(rd_busy),      64'(0));

    // No R1 at all.
    start_read(32'h0000_0099, MODE_SILENT);
    wait_done(1000, "resp_to_done");
    check("resp_to_flag",    64'(rd_err),              64'(1));
    check("resp_to_latency", 64'(done_cyc - busy_cyc), 64'(313));

    // R1 fine, token never arrives.
    start_read(32'h0000_00A5, MODE_NOTOKEN);
    wait_done(70000, "tok_to_done");
    check("tok_to_flag",    64'(rd_err),              64'(1));
    check("tok_to_latency", 64'(done_cyc - busy_cyc), 64'(65612));
    check("tok_to_no_data", 64'(rd_valid_cnt),        64'(0));

    // Reset in the middle of the data phase.
    d0 = done_cnt;
    start_read(32'h00AB_CDEF, MODE_GOOD);
    check("err_cleared_on_accept", 64'(rd_err), 64'(0));
    wait_valid(200, 3000, "midreset_reach200");
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    exp_data_q.delete();
    miso_q.delete();
    repeat (3) @(posedge SD_clk);
    @(negedge SD_clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge SD_clk);
    #1;
    check("midreset_no_done", 64'(done_cnt - d0), 64'(0));

    // Good read, then a second request on the cycle after rd_done.
    d0 = done_cnt;
    start_read(32'h0000_0777, MODE_GOOD);
    wait_done(6000, "good2_done");
    check_good_tail("good2");
    start_read(32'hFFFF_FFFF, MODE_GOOD);
    wait_done(6000, "b2b_done");
    check_good_tail("b2b");
    check("b2b_two_dones", 64'(done_cnt - d0), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
